// File: rtl/layer_fb_ram.sv
// ---------------------------------------------------------------------------
// layer_fb_ram
// Single-clock layer framebuffer for the VGA compositor. Storage is an
// inferred block RAM of H_RES*V_RES pixels. One write port is shared between
// the drawing logic and a built-in clear engine. One registered read port
// serves scan-out and compositing.
//
// Clear behaviour
//   Reset starts a full-frame clear with CLEAR_VAL. A later clr_req starts a
//   clear with the latched clr_color. The engine writes one pixel per clock.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wr_en/addr/data user pixel write (linear address y*H_RES+x)
//   rd_en/addr      read request; rd_data/rd_valid follow one cycle later
//   clr_req/color   request a full-frame clear with the given fill
//   busy            a clear is in progress
//   clr_done        one-cycle pulse after the last clear write
//   wr_drop         one-cycle pulse when a user write was discarded
// ---------------------------------------------------------------------------
module layer_fb_ram #(
    parameter int              H_RES     = 320,
    parameter int              V_RES     = 240,
    parameter int              PIX_W     = 3,
    parameter logic [PIX_W-1:0] CLEAR_VAL = {PIX_W{1'b1}},
    parameter int              ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_color,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The range compare uses one extra bit so that DEPTH == 2**ADDR_W still works.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // Storage. It has no reset, so it maps onto block RAM.
    logic [PIX_W-1:0] ram [DEPTH];

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
    logic [PIX_W-1:0]  fill_reg, fill_next;
    logic              clr_done_next;
    logic              wr_drop_next;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [PIX_W-1:0]  mem_data;
    logic              wr_accept;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Next-state logic and write-port arbitration
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        fill_next     = fill_reg;
        clr_done_next = 1'b0;
        mem_we        = 1'b0;
        mem_idx       = wr_addr[IDX_W-1:0];
        mem_data      = wr_data;
        wr_accept     = 1'b0;

        case (state_reg)
            CLEAR: begin
                // The clear engine owns the write port. clr_req is ignored here.
                mem_we   = 1'b1;
                mem_idx  = clr_cnt_reg[IDX_W-1:0];
                mem_data = fill_reg;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_done_next = 1'b1;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                // A clear request wins over a write in the same cycle.
                if (clr_req) begin
                    fill_next    = clr_color;
                    clr_cnt_next = '0;
                    state_next   = CLEAR;
                end else if (wr_en && wr_in_range) begin
                    wr_accept = 1'b1;
                    mem_we    = 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase

        wr_drop_next = wr_en && !wr_accept;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            fill_reg    <= CLEAR_VAL;
            clr_done    <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            fill_reg    <= fill_next;
            clr_done    <= clr_done_next;
            wr_drop     <= wr_drop_next;
        end
    end

    // busy comes straight from the state register. Reset therefore forces it high.
    assign busy = (state_reg == CLEAR);

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ram[mem_idx] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // RAM read port. The read is read-first: a same-cycle write to the same
    // address returns the old contents, because both sides use nonblocking
    // updates. rd_data holds its value while rd_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? ram[rd_idx] : '0;
            end
        end
    end

endmodule
